// File: rtl/count_capture_if.sv
// -----------------------------------------------------------------------------
// count_capture_if
//   Bundles the trigger/counter inputs, the timestamp valid/ready stream and
//   the status outputs of count_capture into one interface.
//
//   Signals
//     en        capture enable (trigger edges ignored while low)
//     trig      event trigger, synchronous to clk
//     count_in  counter value to timestamp
//     out_data  head-of-FIFO timestamp
//     out_valid out_data valid (FIFO not empty)
//     out_ready consumer accepts out_data this cycle
//     level     number of stored entries, 0..DEPTH
//     overflow  sticky: an event was dropped while full
//     clr_ovf   synchronous clear of overflow
//
//   Modports
//     master    the side that drives triggers and consumes timestamps
//     slave     the count_capture block itself
// -----------------------------------------------------------------------------
interface count_capture_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 2
);
   logic                  en;
   logic                  trig;
   logic [DATA_WIDTH-1:0] count_in;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [ADDR_WIDTH:0]   level;
   logic                  overflow;
   logic                  clr_ovf;

   modport master (
      output en, trig, count_in, out_ready, clr_ovf,
      input  out_data, out_valid, level, overflow
   );

   modport slave (
      input  en, trig, count_in, out_ready, clr_ovf,
      output out_data, out_valid, level, overflow
   );
endinterface

// File: rtl/count_capture.sv
// -----------------------------------------------------------------------------
// count_capture
//   Timestamps qualified rising edges of a trigger with the current counter
//   value. Timestamps are queued in a small first-word fall-through FIFO and
//   offered on a valid/ready stream. Events arriving while the FIFO is full
//   (and nothing is leaving that cycle) are dropped and flagged by a sticky
//   overflow bit.
//
//   Ports
//     clk   in  system clock, all logic on posedge
//     rst   in  asynchronous, active-low reset (0 = reset)
//     bus   slave modport of count_capture_if (trigger inputs, timestamp
//           stream, level and overflow status)
//
//   Parameters
//     DATA_WIDTH  timestamp width
//     DEPTH       FIFO entries, power of 2, >= 2
//     ADDR_WIDTH  log2(DEPTH)
// -----------------------------------------------------------------------------
module count_capture #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   count_capture_if.slave  bus
);

   localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] ONE_LEVEL  = (ADDR_WIDTH+1)'(1);

   logic                  r_trig_d;
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ADDR_WIDTH:0]   r_level;
   logic                  r_overflow;

   logic                  w_event;
   logic                  w_pop;
   logic                  w_full;
   logic                  w_push;
   logic                  w_drop;
   logic [DATA_WIDTH-1:0] w_entries [DEPTH];

   // Rising edge of trig, qualified by en. The delayed copy tracks trig even
   // while en is low, so enabling during a held-high trigger yields no event.
   assign w_event = bus.en & bus.trig & ~r_trig_d;
   assign w_full  = (r_level == FULL_LEVEL);
   assign w_pop   = (r_level != '0) & bus.out_ready;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign w_push  = w_event & (~w_full | w_pop);
   assign w_drop  = w_event & w_full & ~w_pop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_trig_d   <= 1'b0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_trig_d <= bus.trig;

         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end

         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + ONE_LEVEL;
            2'b01:   r_level <= r_level - ONE_LEVEL;
            default: r_level <= r_level;
         endcase

         // A drop in the same cycle as a clear leaves the flag set.
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (bus.clr_ovf) begin
            r_overflow <= 1'b0;
         end
      end
   end

   // Storage is cleared by reset so out_data reads 0 while empty after reset.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [DATA_WIDTH-1:0] r_entry;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_entry <= '0;
            end else if (w_push && (r_wr_ptr == ADDR_WIDTH'(gi))) begin
               r_entry <= bus.count_in;
            end
         end

         assign w_entries[gi] = r_entry;
      end
   endgenerate

   assign bus.out_data  = w_entries[r_rd_ptr];
   assign bus.out_valid = (r_level != '0);
   assign bus.level     = r_level;
   assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_count_capture.sv
module tb_count_capture;
   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   count_capture_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifc ();

   count_capture #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: FIFO contents as a queue, sticky flag, previous trig.
   logic [DW-1:0] mdl_fifo [$];
   // Scoreboard: timestamps expected on the output stream, in order.
   logic [DW-1:0] exp_q [$];
   logic          mdl_ovf       = 1'b0;
   logic          mdl_prev_trig = 1'b0;

   function automatic void check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endfunction

   // Applies the rules for one clock edge given the inputs seen at that edge.
   task automatic model_step(input logic e, input logic t, input logic [DW-1:0] c,
                             input logic r, input logic cl);
      bit pop;
      bit ev;
      bit full;
      pop  = (mdl_fifo.size() != 0) && r;
      ev   = e && t && !mdl_prev_trig;
      full = (mdl_fifo.size() == DEPTH);
      mdl_prev_trig = t;
      if (pop) void'(mdl_fifo.pop_front());
      if (ev && (!full || pop)) begin
         mdl_fifo.push_back(c);
         exp_q.push_back(c);
      end
      if (ev && full && !pop) mdl_ovf = 1'b1;
      else if (cl)            mdl_ovf = 1'b0;
   endtask

   // Drive one cycle of inputs (called #1 after a posedge), then update model.
   task automatic cycle(input logic e, input logic t, input logic [DW-1:0] c,
                        input logic r, input logic cl);
      ifc.en        = e;
      ifc.trig      = t;
      ifc.count_in  = c;
      ifc.out_ready = r;
      ifc.clr_ovf   = cl;
      @(posedge clk);
      #1;
      model_step(e, t, c, r, cl);
   endtask

   task automatic drain();
      for (int i = 0; i < 2 * DEPTH && mdl_fifo.size() != 0; i++) begin
         cycle(1'b1, 1'b0, 8'd0, 1'b1, 1'b0);
      end
      check("drained_valid", int'(ifc.out_valid), 0);
   endtask

   // Monitor: compares status every cycle mid-period, and pops the scoreboard
   // whenever the DUT hands over a timestamp.
   initial begin
      logic [DW-1:0] exp_v;
      forever begin
         @(negedge clk);
         if (rst) begin
            check("level", int'(ifc.level), mdl_fifo.size());
            check("overflow", int'(ifc.overflow), int'(mdl_ovf));
            check("out_valid", int'(ifc.out_valid), int'(mdl_fifo.size() != 0));
            if (ifc.out_valid && ifc.out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL pop_data: got %0d, expected no output", ifc.out_data);
               end else begin
                  exp_v = exp_q.pop_front();
                  $display("pop data=%0d expected=%0d", ifc.out_data, exp_v);
                  check("pop_data", int'(ifc.out_data), int'(exp_v));
               end
            end
         end
      end
   end

   initial begin
      logic [DW-1:0] vals [5];
      vals = '{8'd21, 8'd23, 8'd25, 8'd27, 8'd29};

      ifc.en = 1'b0; ifc.trig = 1'b0; ifc.count_in = '0;
      ifc.out_ready = 1'b0; ifc.clr_ovf = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_level", int'(ifc.level), 0);
      check("rst_valid", int'(ifc.out_valid), 0);
      check("rst_overflow", int'(ifc.overflow), 0);
      check("rst_data", int'(ifc.out_data), 0);
      rst = 1'b1;

      // Reset mid-operation with 3 entries stored
      cycle(1, 0, 8'd0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cycle(1, 1, 8'(10 + i), 0, 0);
         cycle(1, 0, 8'd0, 0, 0);
      end
      check("pre_reset_level", int'(ifc.level), 3);
      #2 rst = 1'b0;
      #1;
      check("async_rst_level", int'(ifc.level), 0);
      check("async_rst_valid", int'(ifc.out_valid), 0);
      check("async_rst_overflow", int'(ifc.overflow), 0);
      mdl_fifo.delete();
      exp_q.delete();
      mdl_ovf = 1'b0;
      mdl_prev_trig = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;

      // Trig held high produces one entry
      cycle(1, 0, 8'd19, 0, 0);
      cycle(1, 1, 8'd20, 0, 0);
      check("hold_first_valid", int'(ifc.out_valid), 1);
      check("hold_first_data", int'(ifc.out_data), 20);
      for (int i = 0; i < 4; i++) cycle(1, 1, 8'(21 + i), 0, 0);
      check("hold_level", int'(ifc.level), 1);
      check("hold_data", int'(ifc.out_data), 20);
      drain();

      // Overflow on fifth event, then ordered drain
      foreach (vals[i]) begin
         cycle(1, 1, vals[i], 0, 0);
         cycle(1, 0, vals[i] + 8'd1, 0, 0);
      end
      check("full_level", int'(ifc.level), 4);
      check("full_overflow", int'(ifc.overflow), 1);
      check("full_head", int'(ifc.out_data), 21);
      drain();

      // clr_ovf clears the flag
      cycle(1, 0, 8'd0, 0, 1);
      check("clr_overflow", int'(ifc.overflow), 0);

      // Full with simultaneous pop and event
      for (int i = 0; i < 4; i++) begin
         cycle(1, 1, 8'(40 + 2 * i), 0, 0);
         cycle(1, 0, 8'd0, 0, 0);
      end
      cycle(1, 1, 8'd31, 1, 0);
      check("pushpop_level", int'(ifc.level), 4);
      check("pushpop_overflow", int'(ifc.overflow), 0);
      check("pushpop_head", int'(ifc.out_data), 42);

      // clr_ovf coincident with a drop: set wins
      cycle(1, 0, 8'd0, 0, 0);
      cycle(1, 1, 8'd33, 0, 1);
      check("clr_vs_drop_overflow", int'(ifc.overflow), 1);
      check("clr_vs_drop_level", int'(ifc.level), 4);
      drain();
      cycle(1, 0, 8'd0, 0, 1);

      // Enable qualification
      cycle(0, 0, 8'd0, 0, 0);
      cycle(0, 1, 8'd50, 0, 0);
      check("en_low_level", int'(ifc.level), 0);
      cycle(1, 1, 8'd51, 0, 0);
      cycle(1, 1, 8'd51, 0, 0);
      check("en_rise_level", int'(ifc.level), 0);
      cycle(1, 0, 8'd0, 0, 0);
      cycle(1, 1, 8'd52, 0, 0);
      check("en_edge_level", int'(ifc.level), 1);
      check("en_edge_data", int'(ifc.out_data), 52);
      drain();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom % 4) != 0, $urandom % 2, 8'($urandom),
               $urandom_range(0, 2) == 0, ($urandom % 8) == 0);
      end
      drain();
      check("final_scoreboard_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
